// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and constants for the data-memory bus bridge.
//   state_t : bridge FSM states (IDLE, REQ, WAIT, DONE)
//   F3_*    : MEM-stage funct3 access size/sign codes
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_bus_bridge_lsu_align.sv
// lsu_align: combinational byte-lane formatter for the data-memory bridge.
//   funct3    in  access size/sign (undefined codes behave as word)
//   addr_lo   in  byte offset within the word
//   wr_data   in  store data (low bits significant)
//   bus_rdata in  raw read word from the bus
//   wstrb     out byte strobes for a store
//   wdata     out lane-replicated store data
//   load_data out lane-selected, sign/zero-extended load result
//   misaligned out access does not fit its natural alignment
module lsu_align
  import dmem_bridge_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  // Addressed byte/half moved down to bit 0.
  logic [15:0] lane_word;
  assign lane_word = 16'(bus_rdata >> {addr_lo, 3'b000});

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    misaligned = 1'b0;
    wstrb      = 4'b1111;
    wdata      = wr_data;
    load_data  = bus_rdata;
    case (funct3)
      F3_B, F3_BU: begin
        wdata     = {4{wr_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        load_data = {{24{(funct3 == F3_B) & lane_word[7]}}, lane_word[7:0]};
      end
      F3_H, F3_HU: begin
        misaligned = addr_lo[0];
        wdata      = {2{wr_data[15:0]}};
        wstrb      = 4'b0011 << addr_lo;
        load_data  = {{16{(funct3 == F3_H) & lane_word[15]}}, lane_word[15:0]};
      end
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: converts MEM-stage load/store requests into a valid/ready
// request channel plus a read-response channel, stalling the pipeline until
// each access completes, is rejected as misaligned, or times out.
//   clk, reset               clock, async active-high reset
//   mem_read, mem_write      MEM-stage request (write wins if both set)
//   addr, wr_data, funct3    access address, store data, size/sign
//   stall                    combinational pipeline hold
//   rd_data, rd_valid        load result and its one-cycle strobe
//   misalign_err, bus_err    one-cycle error pulses
//   bus_req_valid/ready, bus_we, bus_addr, bus_wdata, bus_wstrb  request channel
//   bus_resp_valid, bus_rdata                                    response channel
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  misalign_err,
  output logic                  bus_err,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [DM_ADDRESS-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_resp_valid,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic                  req_valid_q, we_q, rd_valid_q, misalign_q, berr_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q, rd_data_q;
  logic [3:0]            wstrb_q;

  logic        is_req;
  logic        timed_out;
  logic [CNT_W-1:0] cnt_sat;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned;

  assign is_req    = mem_read | mem_write;
  assign timed_out = (cnt_q == CNT_LAST);
  // Saturates so a request accepted on its last allowed cycle cannot wrap the
  // counter and grant WAIT a fresh budget.
  assign cnt_sat   = timed_out ? cnt_q : cnt_q + 1'b1;

  // Live inputs are formatted while deciding in IDLE; afterwards the captured
  // size and lane steer load formatting when the response arrives.
  assign al_f3 = (state_q == IDLE) ? funct3    : f3_q;
  assign al_lo = (state_q == IDLE) ? addr[1:0] : lane_q;

  lsu_align u_align (
    .funct3    (al_f3),
    .addr_lo   (al_lo),
    .wr_data   (wr_data),
    .bus_rdata (bus_rdata),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .load_data (al_load),
    .misaligned(al_misaligned)
  );

  assign stall = ((state_q == IDLE) & is_req) | (state_q == REQ) | (state_q == WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      // Status pulses are only ever set on the edge into DONE.
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      berr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (is_req) begin
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            we_q   <= mem_write;
            if (al_misaligned) begin
              misalign_q <= 1'b1;
              if (!mem_write) rd_data_q <= '0;
              state_q <= DONE;
            end else begin
              req_valid_q <= 1'b1;
              addr_q      <= {addr[DM_ADDRESS-1:2], 2'b00};
              wdata_q     <= mem_write ? al_wdata : '0;
              wstrb_q     <= mem_write ? al_wstrb : 4'b0000;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_sat;
          if (bus_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= we_q ? DONE : WAIT;
          end else if (timed_out) begin
            req_valid_q <= 1'b0;
            berr_q      <= 1'b1;
            if (!we_q) rd_data_q <= '0;
            state_q     <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_sat;
          if (bus_resp_valid) begin
            rd_data_q  <= al_load;
            rd_valid_q <= 1'b1;
            state_q    <= DONE;
          end else if (timed_out) begin
            berr_q    <= 1'b1;
            rd_data_q <= '0;
            state_q   <= DONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_req_valid = req_valid_q;
  assign bus_we        = we_q & req_valid_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = wstrb_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = berr_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed scoreboard bench for dmem_bus_bridge.
// A bus-slave process answers requests and checks them against an expected
// request queue; a monitor pops expected responses whenever the DUT pulses
// rd_valid, misalign_err or bus_err.
module tb_dmem_bus_bridge;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read, mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    funct3;
  logic          stall;
  logic [DW-1:0] rd_data;
  logic          rd_valid, misalign_err, bus_err;
  logic          bus_req_valid, bus_req_ready, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_wstrb;
  logic          bus_resp_valid;
  logic [DW-1:0] bus_rdata;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.DM_ADDRESS(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wr_data(wr_data), .funct3(funct3), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .misalign_err(misalign_err),
    .bus_err(bus_err), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } bus_exp_t;

  // flags = {rd_valid, misalign_err, bus_err}
  typedef struct {
    logic [2:0]  flags;
    logic [31:0] data;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    bus_exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.wstrb = ws;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [2:0] flags, input logic [31:0] d);
    rsp_exp_t e;
    e.flags = flags; e.data = d;
    rsp_q.push_back(e);
  endtask

  // ---------------- bus slave ----------------
  logic [31:0] mem [0:127];
  int          hold_cnt = 0;
  int          lat_cfg = 1;
  int          pend = 0;
  logic [31:0] pend_word;
  int          req_count = 0;
  int          valid_cycles = 0;
  logic        snap_ok = 1'b0;
  logic [45:0] snap;

  initial begin
    bus_exp_t e;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_rdata      = '0;
    forever begin
      @(negedge clk);
      bus_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus_resp_valid = 1'b1;
          bus_rdata      = pend_word;
        end
      end
      bus_req_ready = 1'b0;
      if (bus_req_valid) begin
        valid_cycles++;
        if (snap_ok) check("bus_stable", {18'd0, bus_we, bus_addr, bus_wdata, bus_wstrb}, {18'd0, snap});
        snap    = {bus_we, bus_addr, bus_wdata, bus_wstrb};
        snap_ok = 1'b1;
        if (hold_cnt > 0) begin
          hold_cnt--;
        end else begin
          bus_req_ready = 1'b1;
          req_count++;
          snap_ok = 1'b0;
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected actual=we%b addr=%0h expected none", bus_we, bus_addr);
          end else begin
            e = bus_q.pop_front();
            check("bus_req", {18'd0, bus_we, bus_addr, bus_wdata, bus_wstrb},
                  {18'd0, e.we, e.addr, e.wdata, e.wstrb});
          end
          if (bus_we) begin
            for (int i = 0; i < 4; i++)
              if (bus_wstrb[i]) mem[bus_addr[AW-1:2]][8*i +: 8] = bus_wdata[8*i +: 8];
          end else begin
            pend      = lat_cfg;
            pend_word = mem[bus_addr[AW-1:2]];
          end
        end
      end else begin
        snap_ok = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid || misalign_err || bus_err) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=%b%b%b expected none", rd_valid, misalign_err, bus_err);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_flags", {61'd0, rd_valid, misalign_err, bus_err}, {61'd0, e.flags});
          check("rsp_rd_data", {32'd0, rd_data}, {32'd0, e.data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called on a negedge while the bridge is in IDLE; returns on the negedge
  // after DONE, i.e. the cycle the next request may be presented.
  task automatic access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input int hold, input int lat, input int exp_stall);
    int cnt = 0;
    hold_cnt  = hold;
    lat_cfg   = lat;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wr_data   = wd;
    #1;
    while (stall && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall"}, 64'(cnt), 64'(exp_stall));
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int vc0, rc0, n, rv_seen;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wr_data = '0; funct3 = 3'b010;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_outs", {20'd0, rd_valid, misalign_err, bus_err, bus_req_valid, bus_we, bus_addr, bus_wstrb},
          64'd0);
    check("rst_data", {rd_data, bus_wdata}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store then sign-extending byte load from the top lane.
    exp_bus(1'b1, 9'h010, 32'h8081_82F3, 4'b1111);
    access("sw10", 1'b0, 1'b1, 3'b010, 9'h010, 32'h8081_82F3, 0, 1, 2);
    idle_cycle();
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'hFFFF_FF80);
    access("lb13", 1'b1, 1'b0, 3'b000, 9'h013, 32'h0, 0, 1, 3);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h0000_0080);
    access("lbu13", 1'b1, 1'b0, 3'b100, 9'h013, 32'h0, 0, 1, 3);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h0000_8081);
    access("lhu12", 1'b1, 1'b0, 3'b101, 9'h012, 32'h0, 0, 1, 3);

    // Sub-word stores: word at 0x10 becomes 8081ABF3 then 1234ABF3.
    exp_bus(1'b1, 9'h010, 32'hABAB_ABAB, 4'b0010);
    access("sb11", 1'b0, 1'b1, 3'b000, 9'h011, 32'h0000_00AB, 0, 1, 2);
    exp_bus(1'b1, 9'h010, 32'h1234_1234, 4'b1100);
    access("sh12", 1'b0, 1'b1, 3'b001, 9'h012, 32'h0000_1234, 0, 1, 2);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h1234_ABF3);
    access("lw10_lat3", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 0, 3, 5);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'hFFFF_ABF3);
    access("lh10", 1'b1, 1'b0, 3'b001, 9'h010, 32'h0, 0, 1, 3);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'hFFFF_FFAB);
    access("lb11", 1'b1, 1'b0, 3'b000, 9'h011, 32'h0, 0, 1, 3);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h0000_1234);
    access("lh12", 1'b1, 1'b0, 3'b001, 9'h012, 32'h0, 0, 1, 3);
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h1234_ABF3);
    access("f3_011_as_w", 1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 0, 1, 3);
    idle_cycle();

    // Misaligned accesses never reach the bus.
    vc0 = valid_cycles;
    exp_rsp(3'b010, 32'h0);
    access("lw06_mis", 1'b1, 1'b0, 3'b010, 9'h006, 32'h0, 0, 1, 1);
    exp_rsp(3'b010, 32'h0);
    access("sh03_mis", 1'b0, 1'b1, 3'b001, 9'h003, 32'h5555, 0, 1, 1);
    check("mis_no_req", 64'(valid_cycles - vc0), 64'd0);
    idle_cycle();

    // Backpressure: ready low for 5 cycles while valid.
    exp_bus(1'b1, 9'h040, 32'hCAFE_F00D, 4'b1111);
    access("sw40_bp5", 1'b0, 1'b1, 3'b010, 9'h040, 32'hCAFE_F00D, 5, 1, 7);
    exp_bus(1'b0, 9'h040, 32'h0, 4'b0000); exp_rsp(3'b100, 32'hCAFE_F00D);
    access("lw40_bp2", 1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 2, 2, 6);

    // Timeout: ready never comes; 1 IDLE cycle + TO counted cycles.
    exp_rsp(3'b001, 32'h0);
    access("lw44_timeout", 1'b1, 1'b0, 3'b010, 9'h044, 32'h0, 1000, 1, 1 + TO);
    idle_cycle();
    check("to_idle_valid", {62'd0, stall, bus_req_valid}, 64'd0);

    // Back-to-back load then store: exactly two requests.
    rc0 = req_count;
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000); exp_rsp(3'b100, 32'h1234_ABF3);
    access("b2b_lw", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 0, 1, 3);
    exp_bus(1'b1, 9'h048, 32'h1122_3344, 4'b1111);
    access("b2b_sw", 1'b0, 1'b1, 3'b010, 9'h048, 32'h1122_3344, 0, 1, 2);
    idle_cycle();
    repeat (3) @(negedge clk);
    check("b2b_req_count", 64'(req_count - rc0), 64'd2);

    // Read+write together behaves as a write.
    exp_bus(1'b1, 9'h020, 32'hDEAD_BEEF, 4'b1111);
    access("rw_as_write", 1'b1, 1'b1, 3'b010, 9'h020, 32'hDEAD_BEEF, 0, 1, 2);
    exp_bus(1'b0, 9'h020, 32'h0, 4'b0000); exp_rsp(3'b100, 32'hDEAD_BEEF);
    access("lw20", 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 0, 1, 3);
    idle_cycle();

    // Reset while waiting for a slow response; the late response is ignored.
    rc0 = req_count;
    exp_bus(1'b0, 9'h010, 32'h0, 4'b0000);
    hold_cnt = 0; lat_cfg = 20;
    mem_read = 1'b1; funct3 = 3'b010; addr = 9'h010;
    n = 0;
    while (req_count == rc0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstw_accepted", 64'(req_count - rc0), 64'd1);
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0;
    #1;
    check("rstw_outs", {20'd0, stall, rd_valid, misalign_err, bus_err, bus_req_valid, bus_we, bus_addr,
                        bus_wstrb}, 64'd0);
    check("rstw_data", {32'd0, rd_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (rd_valid) rv_seen++;
    end
    check("rstw_no_rd_valid", 64'(rv_seen), 64'd0);
    check("rstw_pend_done", 64'(pend), 64'd0);

    check("bus_q_empty", 64'(bus_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the pipeline's EX/MEM register, between the MEM stage and a variable-latency data-memory bus.
- Turns MEM-stage load/store requests into a valid/ready request channel plus a response channel.
- Formats byte/half/word accesses and raises a pipeline stall until each access completes.
- Replaces the fixed single-cycle data-memory path, so memory latency can grow without changing pipeline timing.

Parameters:
- DM_ADDRESS, 9, pipeline data-address width (byte address).
- DATA_W, 32, data width; fixed at 32 (four byte lanes).
- TIMEOUT_CYC, 64, cycles in REQ+WAIT before the access is aborted; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  MEM-stage load request; held stable while stall=1.
- mem_write  in  1  MEM-stage store request; held stable while stall=1.
- addr  in  DM_ADDRESS  byte address of the access.
- wr_data  in  DATA_W  store data, taken from the low bits.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall  out  1  holds the pipeline (PC, IF/ID, ID/EX, EX/MEM).
- rd_data  out  DATA_W  formatted load result; valid when rd_valid=1.
- rd_valid  out  1  one-cycle pulse; a load completed.
- misalign_err  out  1  one-cycle pulse; access was misaligned and not issued.
- bus_err  out  1  one-cycle pulse; access timed out.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted when valid & ready.
- bus_we  out  1  1 = write.
- bus_addr  out  DM_ADDRESS  word-aligned address {addr[DM_ADDRESS-1:2],2'b00}.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_wstrb  out  4  byte strobes (0000 on reads).
- bus_resp_valid  in  1  read response valid (writes have no response).
- bus_rdata  in  DATA_W  read word.

Behaviour:
- Reset: state IDLE, timeout counter 0, every registered output 0. stall is combinational, so it is 0 whenever no request is present.
- States:
  - IDLE: if mem_read or mem_write, capture the request (registered address, lanes, strobes) and go to REQ. If the access is misaligned, go to DONE with misalign_err instead. bus_resp_valid is ignored in IDLE.
  - REQ: bus_req_valid=1 with stable bus_* signals. On ready: a write goes to DONE (posted); a read goes to WAIT.
  - WAIT: on bus_resp_valid, latch the formatted load data and go to DONE.
  - DONE: for exactly one cycle, stall=0 and rd_valid/misalign_err/bus_err pulse as applicable; then return to IDLE.
- Stall: stall = (IDLE & request) | REQ | WAIT. The pipeline advances on the DONE edge, and the next request is seen in IDLE the following cycle. There is no re-issue of the same access.
- Latency: with a ready bus, stall cycles = 2 + read latency for a load, 2 for a store, 1 for a misaligned access.
- Write priority: mem_read & mem_write together is illegal and is handled as a write.
- Alignment: H/HU/SH require addr[0]=0; W/SW require addr[1:0]=0. Byte accesses are never misaligned.
- Stores:
  - SB: wdata={4{wr_data[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wr_data[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wstrb=1111.
- Loads: select the byte/half lane from addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W passes the word through.
- Undefined funct3 codes (011, 110, 111) are treated as W.
- Timeout: the counter runs in REQ and WAIT and clears in IDLE. At TIMEOUT_CYC it drops bus_req_valid, goes to DONE with bus_err=1 and rd_data=0.
- Error loads: on misalign or timeout, rd_data=0 and rd_valid=0.
- rd_data holds its value until the next load completion.
- Reset mid-access: asynchronous return to IDLE. Any stale response arriving afterwards is ignored because responses are not accepted in IDLE.
- bus_* signals are held stable throughout REQ (valid/ready protocol rule).

Decomposition:
- Package dmem_bridge_pkg:
  - state_t enum (IDLE, REQ, WAIT, DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_align: purely combinational.
  - Inputs funct3, addr[1:0], wr_data, bus_rdata.
  - Outputs wstrb, wdata, load_data, misaligned.
  - Instantiated once; the FSM and timeout counter live in dmem_bus_bridge.

Test Plan:
- Normal load: SW addr 0x10 data 0x8081_82F3, ready=1 → stall exactly 2 cycles, wstrb=1111. Then LB addr 0x13, 1-cycle response → stall 3 cycles, rd_data=0xFFFF_FF80, rd_valid 1 cycle.
- Sub-word accesses: LBU 0x13 → 0x0000_0080. LHU 0x12 → 0x0000_8081. SB 0x11 data 0xAB → wdata 0xABABABAB, wstrb 0010. SH 0x12 → wstrb 1100.
- Misalign: LW addr 0x06 → no bus_req_valid, misalign_err pulse, stall 1 cycle, rd_data=0. Same for SH addr 0x03.
- Backpressure and timeout: ready held low 5 cycles → bus_* stable throughout, stall persists, then completes. Ready never asserted with TIMEOUT_CYC=8 → bus_err at 8 counted cycles, return to IDLE.
- Reset mid-WAIT: assert reset while in WAIT, then deliver bus_resp_valid after release → outputs 0 immediately, response ignored, rd_valid stays 0.
- Back-to-back: load then store on consecutive DONE edges → exactly two bus requests, no duplicate issue. Simultaneous read+write → treated as a write.
